branch_resolve_ctrl: RTL and testbench

Controller that sequences the branch predictor against the pipeline. It queues every predicted conditional branch from decode, retires them in order when they resolve in the memory stage, and compares prediction with outcome. On a mismatch it drives a one-cycle PC redirect and a timed pipeline flush, and it keeps statistics. It sits between `branch_predictor` (prediction, `branch_addr`), the decode stage and the fetch/PC-select logic.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_fifo.sv | 59 +++++
 rtl/branch_resolve_ctrl.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve controller: FSM states,
// queue entry layout and the fall-through PC increment.
package branch_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Entry layout, MSB first: {pred, pc, target}
    function automatic int unsigned entry_w(input int unsigned aw);
        return 1 + 2 * aw;
    endfunction

    function automatic int unsigned pred_bit(input int unsigned aw);
        return 2 * aw;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned tgt_lsb(input int unsigned aw);
        return (aw > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// In-order queue of unresolved branches. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module branch_fifo #(
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] wr_data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;

    // Storage is written only on accepted pushes; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q[PW-1:0]] <= wr_data_i;
        end
    end

    // Pointer update; clear wins over push/pop in the same cycle.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_o  = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Queues predicted branches from decode, retires them in order at memory
// resolve, and on a mispredict issues a redirect pulse and a timed flush.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | normal operation: pushes and resolves accepted
//  ST_FLUSH | pipeline squash after mispredict; pushes/resolves ignored
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_decode_sig,
    input  logic              prediction,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              branch_mem_sig,
    input  logic              actual_branch_decision,
    output logic              full,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              mispredict,
    output logic              underflow,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int unsigned EW     = entry_w(ADDR_W);
    localparam int unsigned PRED_B = pred_bit(ADDR_W);
    localparam int unsigned PC_L   = pc_lsb(ADDR_W);
    localparam int unsigned TGT_L  = tgt_lsb(ADDR_W);
    localparam int unsigned FCW    = $clog2(FLUSH_CYCLES + 1);

    state_e            state_q, state_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     head, wr_data;
    logic              push_ok, pop_ok, mis, clr, uf_set;
    logic [ADDR_W-1:0] head_pc, head_tgt, redir_d;

    logic              mispredict_q, redirect_valid_q, underflow_q;
    logic [ADDR_W-1:0] redirect_addr_q;
    logic [CNT_W-1:0]  branch_count_q, mispredict_count_q;

    assign wr_data  = {prediction, in_addr, branch_addr};
    assign head_pc  = head[PC_L +: ADDR_W];
    assign head_tgt = head[TGT_L +: ADDR_W];
    assign redir_d  = actual_branch_decision ? head_tgt
                                             : head_pc + ADDR_W'(PC_INC);

    branch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_ok),
        .pop_i     (pop_ok),
        .clear_i   (clr),
        .wr_data_i (wr_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head)
    );

    // Next state, queue control and mispredict detection.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        mis     = 1'b0;
        clr     = 1'b0;
        uf_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (branch_mem_sig) begin
                    if (fifo_empty) begin
                        uf_set = 1'b1;
                    end else begin
                        pop_ok = 1'b1;
                        mis    = (head[PRED_B] != actual_branch_decision);
                    end
                end
                // Younger entries and a same-cycle push are wrong-path.
                if (mis) begin
                    clr     = 1'b1;
                    state_d = ST_FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYCLES - 1);
                end else if (branch_decode_sig && (!fifo_full || pop_ok)) begin
                    push_ok = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) state_d = ST_IDLE;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered outputs/statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            fcnt_q             <= '0;
            mispredict_q       <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_addr_q    <= '0;
            underflow_q        <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            mispredict_q     <= mis;
            redirect_valid_q <= mis;
            if (mis) redirect_addr_q <= redir_d;
            if (uf_set) underflow_q <= 1'b1;
            if (pop_ok && (branch_count_q != '1))
                branch_count_q <= branch_count_q + 1'b1;
            if (mis && (mispredict_count_q != '1))
                mispredict_count_q <= mispredict_count_q + 1'b1;
        end
    end

    assign full             = fifo_full;
    assign flush            = (state_q == ST_FLUSH);
    assign mispredict       = mispredict_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_addr    = redirect_addr_q;
    assign underflow        = underflow_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec, pred, mem, act;
    logic [AW-1:0] pc, tgt;
    logic          full, flush, rv, mp, uf;
    logic [AW-1:0] ra;
    logic [CW-1:0] bc, mc;

    int total = 0;
    int bad   = 0;

    branch_resolve_ctrl #(
        .ADDR_W       (AW),
        .DEPTH        (4),
        .FLUSH_CYCLES (2),
        .CNT_W        (CW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .branch_decode_sig      (dec),
        .prediction             (pred),
        .in_addr                (pc),
        .branch_addr            (tgt),
        .branch_mem_sig         (mem),
        .actual_branch_decision (act),
        .full                   (full),
        .flush                  (flush),
        .redirect_valid         (rv),
        .redirect_addr          (ra),
        .mispredict             (mp),
        .underflow              (uf),
        .branch_count           (bc),
        .mispredict_count       (mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dec, pred;
        logic [31:0] pc, tgt;
        logic        mem, act;
        logic        e_full, e_flush, e_rv;
        logic [31:0] e_ra;
        logic        e_mp, e_uf;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic d, input logic p, input logic [31:0] a,
                                input logic [31:0] t, input logic m, input logic ac,
                                input logic fu, input logic fl, input logic r,
                                input logic [31:0] rav, input logic mpv, input logic ufv,
                                input int bcv, input int mcv);
        vec_t v;
        v.dec = d; v.pred = p; v.pc = a; v.tgt = t; v.mem = m; v.act = ac;
        v.e_full = fu; v.e_flush = fl; v.e_rv = r; v.e_ra = rav;
        v.e_mp = mpv; v.e_uf = ufv; v.e_bc = bcv; v.e_mc = mcv;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got=0x%0h expected=0x%0h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input logic d, input logic p, input logic [31:0] a,
                         input logic [31:0] t, input logic m, input logic ac);
        @(negedge clk);
        dec = d; pred = p; pc = a; tgt = t; mem = m; act = ac;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_full"},  0, 32'(full),  32'd0);
        chk({tag, "_flush"}, 0, 32'(flush), 32'd0);
        chk({tag, "_rv"},    0, 32'(rv),    32'd0);
        chk({tag, "_ra"},    0, ra,         32'd0);
        chk({tag, "_mp"},    0, 32'(mp),    32'd0);
        chk({tag, "_uf"},    0, 32'(uf),    32'd0);
        chk({tag, "_bc"},    0, 32'(bc),    32'd0);
        chk({tag, "_mc"},    0, 32'(mc),    32'd0);
    endtask

    initial begin
        int exp_bc, exp_mc;
        reset = 1'b1;
        dec = 0; pred = 0; pc = '0; tgt = '0; mem = 0; act = 0;

        //        dec pred pc           tgt       mem act | full fl rv ra          mp uf bc mc
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,0,0,0));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,0,0,32'h0,       0,1,0,0));
        vecs.push_back(mk(1,1,32'h84,     32'h100,  0,0,   0,0,0,32'h0,       0,1,0,0));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,1,0,0));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,0,0,32'h0,       0,1,1,0));
        vecs.push_back(mk(1,1,32'h84,     32'h100,  0,0,   0,0,0,32'h0,       0,1,1,0));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,0,   0,1,1,32'h88,      1,1,2,1));
        vecs.push_back(mk(1,0,32'h200,    32'h300,  0,0,   0,1,0,32'h0,       0,1,2,1));
        vecs.push_back(mk(1,0,32'h200,    32'h300,  0,0,   0,0,0,32'h0,       0,1,2,1));
        vecs.push_back(mk(1,0,32'h200,    32'h300,  0,0,   0,0,0,32'h0,       0,1,2,1));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,1,1,32'h300,     1,1,3,2));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,1,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,1,32'h1000,   32'h2000, 0,0,   0,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,0,32'h1010,   32'h2010, 0,0,   0,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,1,32'h1020,   32'h2020, 0,0,   0,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,0,32'h1030,   32'h2030, 0,0,   1,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,1,32'h1040,   32'h2040, 0,0,   1,0,0,32'h0,       0,1,3,2));
        vecs.push_back(mk(1,1,32'h1040,   32'h2040, 1,1,   1,0,0,32'h0,       0,1,4,2));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,0,   0,0,0,32'h0,       0,1,5,2));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,0,   0,1,1,32'h1024,    1,1,6,3));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,1,0,32'h0,       0,1,6,3));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,1,6,3));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,0,0,32'h0,       0,1,6,3));
        vecs.push_back(mk(1,1,32'hFFFFFFFC,32'h40,  0,0,   0,0,0,32'h0,       0,1,6,3));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,0,   0,1,1,32'h0,       1,1,7,4));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,1,0,32'h0,       0,1,7,4));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,1,7,4));
        vecs.push_back(mk(1,0,32'h500,    32'h600,  0,0,   0,0,0,32'h0,       0,1,7,4));
        vecs.push_back(mk(1,1,32'h700,    32'h800,  1,1,   0,1,1,32'h600,     1,1,8,5));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,1,0,32'h0,       0,1,8,5));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    0,0,   0,0,0,32'h0,       0,1,8,5));
        vecs.push_back(mk(0,0,32'h0,      32'h0,    1,1,   0,0,0,32'h0,       0,1,8,5));

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].dec, vecs[i].pred, vecs[i].pc, vecs[i].tgt, vecs[i].mem, vecs[i].act);
            chk("full",  i, 32'(full),  32'(vecs[i].e_full));
            chk("flush", i, 32'(flush), 32'(vecs[i].e_flush));
            chk("rv",    i, 32'(rv),    32'(vecs[i].e_rv));
            if (vecs[i].e_rv) chk("ra", i, ra, vecs[i].e_ra);
            chk("mp",    i, 32'(mp),    32'(vecs[i].e_mp));
            chk("uf",    i, 32'(uf),    32'(vecs[i].e_uf));
            chk("bc",    i, 32'(bc),    32'(vecs[i].e_bc));
            chk("mc",    i, 32'(mc),    32'(vecs[i].e_mc));
        end

        // Saturation of both counters (4-bit instance).
        exp_bc = 8;
        exp_mc = 5;
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 32'h10, 32'h20, 0, 0);
            drive(0, 0, 32'h0, 32'h0, 1, 0);
            if (exp_bc < 15) exp_bc++;
            if (exp_mc < 15) exp_mc++;
            chk("sat_mp", k, 32'(mp), 32'd1);
            chk("sat_ra", k, ra, 32'h14);
            chk("sat_bc", k, 32'(bc), 32'(exp_bc));
            chk("sat_mc", k, 32'(mc), 32'(exp_mc));
            drive(0, 0, 32'h0, 32'h0, 0, 0);
            drive(0, 0, 32'h0, 32'h0, 0, 0);
        end

        // Async reset with a full queue: queue must come back empty.
        for (int k = 0; k < 4; k++) drive(1, 0, 32'h40 + 32'(k), 32'h80, 0, 0);
        chk("pre_rst_full", 0, 32'(full), 32'd1);
        #2 reset = 1'b1;
        #1 chk_zero("rst_full");
        @(negedge clk);
        reset = 1'b0;
        dec = 0;
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        chk("post_rst_uf", 0, 32'(uf), 32'd1);
        chk("post_rst_bc", 0, 32'(bc), 32'd0);
        chk("post_rst_mp", 0, 32'(mp), 32'd0);

        // Async reset during flush cycle 1.
        drive(1, 1, 32'h84, 32'h100, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        chk("pre_rst_flush", 0, 32'(flush), 32'd1);
        chk("pre_rst_rv",    0, 32'(rv),    32'd1);
        chk("pre_rst_ra",    0, ra,         32'h88);
        #2 reset = 1'b1;
        #1 chk_zero("rst_flush");
        @(negedge clk);
        reset = 1'b0;
        mem = 0;
        drive(1, 0, 32'h900, 32'h904, 0, 0);
        chk("after_rst_flush", 0, 32'(flush), 32'd0);
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        chk("after_rst_bc", 0, 32'(bc), 32'd1);
        chk("after_rst_mp", 0, 32'(mp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
